dbus_arbiter: RTL and testbench
===============================

# dbus_arbiter

Two-port arbiter sharing the single data-bus master port (dbus_req_t/dbus_resp_t) between the instruction-fetch path (port 0) and the memory stage (port 1). It latches the winning request, holds it stable on the downstream bus until `data_ok`, and routes the response back to the owning requester only. Sits between the pipeline and the cache/bus-converter.

## Interface
- No parameters; two requester ports, fixed.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req0  in  dbus_req_t  fetch-side request; `valid` held until own `data_ok`
- resp0  out  dbus_resp_t  fetch-side response
- req1  in  dbus_req_t  memory-stage request; `valid` held until own `data_ok`
- resp1  out  dbus_resp_t  memory-stage response
- mreq  out  dbus_req_t  shared downstream request
- mresp  in  dbus_resp_t  shared downstream response
- owner  out  1  port currently granted (valid only when `busy`=1)
- busy  out  1  transaction outstanding downstream

## Operation
- State: `IDLE`, `BUSY`. Registers: hold (a dbus_req_t copy), `owner`, `last` (port granted most recently).
- IDLE:
  - If neither `req0.valid` nor `req1.valid` is set, stay.
  - Otherwise select a winner per Configuration, copy its request into hold, set `owner` and `last` to the winner, and go to BUSY.
- BUSY:
  - `mreq` = hold with `valid`=1; hold is not updated.
  - `resp[owner]` = `mresp` (`addr_ok`, `data_ok`, `data`). `resp[~owner]` = all zeros.
  - When `mresp.data_ok`=1, go to IDLE.
- IDLE outputs: `mreq` = all zeros, both `resp` = all zeros.
- Requester dropping `valid` mid-transaction: the transaction completes downstream anyway. `data_ok` is still pulsed to that port and the requester ignores it. There is no abort.
- A requester changing `addr`/`data`/`strobe` while owned has no effect, because hold is frozen.
- Non-owner `valid` held during BUSY: it waits and is never lost, since `valid` stays asserted.
- `last` updates only on grant, never on completion.

## Timing
- Reset values, asynchronous, also applied mid-transaction:
  - state=IDLE, `busy`=0, `owner`=0, `last`=1 (so port 0 wins first under round-robin), hold=0.
  - `mreq`=0, `resp0`=0, `resp1`=0.
- Reset mid-transaction abandons the downstream transfer; downstream is reset by the same signal.
- Grant latency: a request sampled in IDLE at edge N puts `mreq.valid`=1 from cycle N+1.
- Response path is combinational: `resp[owner].data_ok` is in the same cycle as `mresp.data_ok`.
- Minimum transaction: 2 cycles (grant cycle + 1 BUSY cycle with immediate `data_ok`).
- Back-to-back: after the `data_ok` cycle, the arbiter spends one IDLE cycle before the next grant. Throughput is at most one transfer per 2 cycles.
- `busy`=1 exactly in BUSY. `owner` is stable for the whole BUSY interval.
- Requester combinational loop: `resp` depends on `mresp` and registers only, never on `req*`.

## Configuration
- `DBUS_ARB_RR_EN` defined: round-robin.
  - Both requesting: the winner is the port ≠ `last`.
  - One requesting: that port wins.
- `DBUS_ARB_RR_EN` undefined: fixed priority. Port 1 (memory stage) always wins when requesting; `last` is still maintained but unused.

## Test plan
- Single request: `req1`={valid=1, addr=0x80001000, size=MSIZE8}, `mresp.data_ok` after 3 BUSY cycles with data=0xDEADBEEF → `mreq` matches from cycle+1, `resp1.data_ok`=1 with data 0xDEADBEEF, `resp0` all zeros, then IDLE.
- Simultaneous requests, RR enabled, held for 4 transactions with immediate `data_ok` → grants 0,1,0,1. Fixed priority → grants 1,1,1,1 while `req1` stays valid.
- Hold stability: `req0` owned, `req0.addr` changed 0x100→0x200 mid-BUSY → `mreq.addr` stays 0x100 until `data_ok`.
- Requester withdraws: `req1` granted, `valid` dropped next cycle → `mreq.valid` stays 1 until `data_ok`. Then IDLE with no re-grant.
- Async reset asserted mid-BUSY, between edges → `mreq`, `resp0`, `resp1`, `busy` go to 0 immediately. After release, the first simultaneous request is granted to port 0 (RR).
- `mresp.addr_ok`/`data_ok` pulsed while IDLE → both `resp` stay zero and state stays IDLE.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared data-bus request/response payload types for the pipeline-to-memory path.
package dbus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      msize_t            size;
      logic [STRB_W-1:0] strobe;
      logic [DATA_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [DATA_W-1:0] data;
   } dbus_resp_t;

endpackage

// File: rtl/dbus_arbiter.sv
// Two-port data-bus arbiter: fetch (port 0) and memory stage (port 1) share one master port.
// Define DBUS_ARB_RR_EN for round-robin; default is fixed priority with port 1 winning.
module dbus_arbiter
   import dbus_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  dbus_req_t  req0,
   output dbus_resp_t resp0,
   input  dbus_req_t  req1,
   output dbus_resp_t resp1,
   output dbus_req_t  mreq,
   input  dbus_resp_t mresp,
   output logic       owner,
   output logic       busy
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e    state_q, state_d;
   dbus_req_t hold_q, hold_d;
   logic      owner_q, owner_d;
   logic      last_q, last_d;
   logic      winner_c;

   // Winner selection, evaluated only when at least one port is requesting.
   always_comb begin
`ifdef DBUS_ARB_RR_EN
      if (req0.valid && req1.valid) begin
         winner_c = ~last_q;
      end else begin
         winner_c = req1.valid;
      end
`else
      winner_c = req1.valid;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Next state: grant latches the request; hold stays frozen until data_ok.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      owner_d = owner_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (req0.valid || req1.valid) begin
               state_d      = BUSY;
               hold_d       = winner_c ? req1 : req0;
               hold_d.valid = 1'b1;
               owner_d      = winner_c;
               last_d       = winner_c;
            end
         end
         BUSY: begin
            if (mresp.data_ok) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus-side outputs derive from registers and mresp only, never from req*.
   always_comb begin
      mreq  = '0;
      resp0 = '0;
      resp1 = '0;
      if (state_q == BUSY) begin
         mreq       = hold_q;
         mreq.valid = 1'b1;
         if (owner_q) begin
            resp1 = mresp;
         end else begin
            resp0 = mresp;
         end
      end
   end

   assign busy  = (state_q == BUSY);
   assign owner = owner_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter; grant/response expectations go through a scoreboard queue.
module tb_dbus_arbiter;
   import dbus_pkg::*;

   logic       clk;
   logic       reset;
   dbus_req_t  req0, req1, mreq;
   dbus_resp_t resp0, resp1, mresp;
   logic       owner, busy;

   typedef struct {
      logic        owner;
      logic [63:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   dbus_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .req0  (req0),
      .resp0 (resp0),
      .req1  (req1),
      .resp1 (resp1),
      .mreq  (mreq),
      .mresp (mresp),
      .owner (owner),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      req0  = '0;
      req1  = '0;
      mresp = '0;
      tick();
      reset = 1'b0;
   endtask

   // Builds the expected round-robin or fixed-priority grant when both ports request.
   function automatic logic both_winner(input logic last);
`ifdef DBUS_ARB_RR_EN
      return ~last;
`else
      return last | 1'b1;
`endif
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      req0  = '0;
      req1  = '0;
      mresp = '0;
      tick();
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b exp=0", owner); end
      checks++; if (mreq !== '0) begin failures++; $display("FAIL reset_mreq got=%h exp=0", mreq); end
      checks++; if (resp0 !== '0 || resp1 !== '0) begin failures++; $display("FAIL reset_resp got=%h/%h exp=0", resp0, resp1); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      dbus_req_t exp_req;
      exp_t      e;
      apply_reset();
      req1        = '0;
      req1.valid  = 1'b1;
      req1.addr   = 32'h8000_1000;
      req1.size   = MSIZE8;
      req1.strobe = 8'hFF;
      exp_req     = req1;
      sb_q.push_back('{owner: 1'b1, data: 64'hDEAD_BEEF});
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) begin
            mresp.data_ok = 1'b1;
            mresp.data    = 64'hDEAD_BEEF;
         end
         #1;
         checks++; if (mreq !== exp_req || busy !== 1'b1) begin failures++; $display("FAIL single_mreq cyc=%0d got=%h busy=%b exp=%h", i, mreq, busy, exp_req); end
      end
      e = sb_q.pop_front();
      checks++; if (owner !== e.owner) begin failures++; $display("FAIL single_owner got=%b exp=%b", owner, e.owner); end
      checks++; if (resp1.data_ok !== 1'b1 || resp1.data !== e.data) begin failures++; $display("FAIL single_resp1 got=%h exp_data=%h", resp1, e.data); end
      checks++; if (resp0 !== '0) begin failures++; $display("FAIL single_resp0 got=%h exp=0", resp0); end
      req1 = '0;
      tick();
      mresp = '0;
      #1;
      checks++; if (busy !== 1'b0 || mreq !== '0) begin failures++; $display("FAIL single_idle busy=%b mreq=%h exp=0", busy, mreq); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic last;
      apply_reset();
      last       = 1'b1;
      req0       = '0;
      req1       = '0;
      req0.valid = 1'b1;
      req0.addr  = 32'h0000_0040;
      req1.valid = 1'b1;
      req1.addr  = 32'h0000_0080;
      for (int k = 0; k < 4; k++) begin
         sb_q.push_back('{owner: both_winner(last), data: 64'(k) + 64'h100});
         last = both_winner(last);
         tick();
         mresp.data_ok = 1'b1;
         mresp.data    = 64'(k) + 64'h100;
         #1;
         e = sb_q.pop_front();
         checks++; if (busy !== 1'b1 || owner !== e.owner) begin failures++; $display("FAIL b2b_grant txn=%0d got=%b busy=%b exp=%b", k, owner, busy, e.owner); end
         checks++; if ((e.owner ? resp1.data : resp0.data) !== e.data || (e.owner ? resp0 : resp1) !== '0) begin failures++; $display("FAIL b2b_route txn=%0d got=%h/%h exp_data=%h", k, resp0, resp1, e.data); end
         tick();
         mresp = '0;
         #1;
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap txn=%0d busy=%b exp=0", k, busy); end
      end
      req0 = '0;
      req1 = '0;
   endtask

   task automatic test_hold();
      exp_t e;
      apply_reset();
      req0       = '0;
      req0.valid = 1'b1;
      req0.addr  = 32'h0000_0100;
      sb_q.push_back('{owner: 1'b0, data: 64'h0123_4567_89AB_CDEF});
      tick();
      checks++; if (mreq.addr !== 32'h100 || owner !== 1'b0) begin failures++; $display("FAIL hold_grant addr=%h owner=%b exp=100/0", mreq.addr, owner); end
      req0.addr = 32'h0000_0200;
      tick();
      checks++; if (mreq.addr !== 32'h100) begin failures++; $display("FAIL hold_mid addr=%h exp=100", mreq.addr); end
      tick();
      mresp.data_ok = 1'b1;
      mresp.data    = 64'h0123_4567_89AB_CDEF;
      #1;
      e = sb_q.pop_front();
      checks++; if (mreq.addr !== 32'h100 || resp0.data_ok !== 1'b1 || resp0.data !== e.data) begin failures++; $display("FAIL hold_done addr=%h resp0=%h exp_data=%h", mreq.addr, resp0, e.data); end
      req0 = '0;
      tick();
      mresp = '0;
   endtask

   task automatic test_withdraw();
      exp_t e;
      apply_reset();
      req1       = '0;
      req1.valid = 1'b1;
      req1.addr  = 32'h0000_0300;
      sb_q.push_back('{owner: 1'b1, data: 64'h55});
      tick();
      req1.valid = 1'b0;
      tick();
      checks++; if (mreq.valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL withdraw_hold valid=%b busy=%b exp=1/1", mreq.valid, busy); end
      tick();
      mresp.data_ok = 1'b1;
      mresp.data    = 64'h55;
      #1;
      e = sb_q.pop_front();
      checks++; if (resp1.data_ok !== 1'b1 || resp1.data !== e.data || owner !== e.owner) begin failures++; $display("FAIL withdraw_done resp1=%h owner=%b exp_data=%h", resp1, owner, e.data); end
      tick();
      mresp = '0;
      tick();
      checks++; if (busy !== 1'b0 || mreq !== '0) begin failures++; $display("FAIL withdraw_regrant busy=%b mreq=%h exp=0", busy, mreq); end
   endtask

   task automatic test_async_reset();
      exp_t e;
      apply_reset();
      req0       = '0;
      req1       = '0;
      req0.valid = 1'b1;
      req1.valid = 1'b1;
      req1.addr  = 32'h0000_0500;
      tick();
      tick();
      mresp.data_ok = 1'b1;
      mresp.data    = 64'hAA;
      #2;
      reset = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || mreq !== '0) begin failures++; $display("FAIL areset_bus busy=%b mreq=%h exp=0", busy, mreq); end
      checks++; if (resp0 !== '0 || resp1 !== '0) begin failures++; $display("FAIL areset_resp got=%h/%h exp=0", resp0, resp1); end
      reset = 1'b0;
      mresp = '0;
      sb_q.push_back('{owner: both_winner(1'b1), data: 64'hBB});
      tick();
      mresp.data_ok = 1'b1;
      mresp.data    = 64'hBB;
      #1;
      e = sb_q.pop_front();
      checks++; if (owner !== e.owner || (e.owner ? resp1.data : resp0.data) !== e.data) begin failures++; $display("FAIL areset_first_grant owner=%b exp=%b", owner, e.owner); end
      req0 = '0;
      req1 = '0;
      tick();
      mresp = '0;
   endtask

   task automatic test_idle_pulse();
      apply_reset();
      mresp.addr_ok = 1'b1;
      mresp.data_ok = 1'b1;
      mresp.data    = 64'hFFFF;
      #1;
      checks++; if (resp0 !== '0 || resp1 !== '0) begin failures++; $display("FAIL idle_pulse_resp got=%h/%h exp=0", resp0, resp1); end
      tick();
      checks++; if (busy !== 1'b0 || resp0 !== '0 || resp1 !== '0) begin failures++; $display("FAIL idle_pulse_state busy=%b exp=0", busy); end
      mresp = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold();
      test_withdraw();
      test_async_reset();
      test_idle_pulse();
      checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
